rdma_rx_buf_sequencer: RTL and testbench

Receive-side buffer sequencer between the RX decapsulator (validated header + payload stream) and an S2MM DMA engine. Per validated packet, allocates one buffer from a fixed ring, issues a DMA write command, gates the payload beats to the DMA, then posts a completion record. Packets with no free buffer or an illegal length are drained and dropped, so the decapsulator never stalls indefinitely.

---
 rtl/rdma_rx_buf_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_rdma_rx_buf_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_rx_buf_sequencer.sv
// -----------------------------------------------------------------------------
// rdma_rx_buf_sequencer
//
// Sits between the RX decapsulator and an S2MM DMA engine. For every validated
// header it claims the next buffer of a fixed ring, issues a DMA write command,
// passes the payload beats straight through to the DMA, and then posts a
// completion record. Packets that find no free buffer, or that carry a zero or
// oversized length, are drained and dropped so the decapsulator never stalls.
//
// Optional feature macro: RDMA_RX_SEQ_LEN_CHECK_EN
//   defined   : payload bytes are counted; o_cpl_len reports the counted bytes
//               and o_cpl_error also flags a count that differs from the header.
//   undefined : no byte counter; o_cpl_len is the header length and
//               o_cpl_error reflects tuser only.
//
// Ports
//   iClk, iRst                 clock, synchronous active-high reset
//   i_hdr_*                    validated header fields, single-cycle i_hdr_valid
//   s_payload_*                payload stream from the decapsulator
//   m_dma_*                    payload stream to the DMA engine
//   o_cmd_*, i_cmd_ready       DMA write command (address, length)
//   o_cpl_*, i_cpl_ready       completion record (buffer, length, source, error)
//   i_rel_valid                software returns the oldest used buffer
//   o_free_count               buffers currently free
//   o_drop_count               dropped packets, saturating
//   o_hdr_overflow             sticky: a header arrived while one was pending
//   o_state                    FSM state code (IDLE=0 CMD=1 DATA=2 CPL=3 DROP=4)
// -----------------------------------------------------------------------------
module rdma_rx_buf_sequencer #(
    parameter int          NUM_BUFS      = 8,
    parameter logic [31:0] BUF_BASE_ADDR = 32'h1000_0000,
    parameter int          BUF_SIZE      = 2048
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [31:0]                 i_hdr_src_ip,
    input  logic [15:0]                 i_hdr_src_port,
    input  logic [15:0]                 i_hdr_payload_len,
    input  logic                        i_hdr_valid,
    input  logic [31:0]                 s_payload_tdata,
    input  logic [3:0]                  s_payload_tkeep,
    input  logic                        s_payload_tvalid,
    input  logic                        s_payload_tlast,
    input  logic                        s_payload_tuser,
    output logic                        s_payload_tready,
    output logic [31:0]                 m_dma_tdata,
    output logic [3:0]                  m_dma_tkeep,
    output logic                        m_dma_tvalid,
    output logic                        m_dma_tlast,
    input  logic                        m_dma_tready,
    output logic [31:0]                 o_cmd_addr,
    output logic [15:0]                 o_cmd_len,
    output logic                        o_cmd_valid,
    input  logic                        i_cmd_ready,
    output logic [$clog2(NUM_BUFS)-1:0] o_cpl_buf_idx,
    output logic [15:0]                 o_cpl_len,
    output logic [31:0]                 o_cpl_src_ip,
    output logic [15:0]                 o_cpl_src_port,
    output logic                        o_cpl_error,
    output logic                        o_cpl_valid,
    input  logic                        i_cpl_ready,
    input  logic                        i_rel_valid,
    output logic [$clog2(NUM_BUFS):0]   o_free_count,
    output logic [15:0]                 o_drop_count,
    output logic                        o_hdr_overflow,
    output logic [2:0]                  o_state
);

    localparam int IDXW = $clog2(NUM_BUFS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_CPL  = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pending;
    logic [31:0]       r_hdr_src_ip;
    logic [15:0]       r_hdr_src_port;
    logic [15:0]       r_hdr_len;

    logic [31:0]       r_cur_src_ip;
    logic [15:0]       r_cur_src_port;
    logic [15:0]       r_cur_len;

    logic [IDXW-1:0]   r_wr_idx;
    logic [IDXW:0]     r_used;
    logic [31:0]       r_cmd_addr;
    logic [15:0]       r_cmd_len;
    logic [15:0]       r_drop_count;
    logic              r_hdr_overflow;
    logic              r_err;

    logic              w_leave_idle;
    logic              w_bad_hdr;
    logic              w_beat_acc;
    logic              w_alloc;
    logic              w_release;

    // A header is rejected for a zero length, a length larger than one
    // buffer, or an empty free pool.
    assign w_bad_hdr    = (r_hdr_len == 16'd0) ||
                          ({16'd0, r_hdr_len} > 32'(BUF_SIZE)) ||
                          (r_used == (IDXW+1)'(NUM_BUFS));
    assign w_leave_idle = (r_state == ST_IDLE) && r_pending;
    assign w_beat_acc   = s_payload_tvalid && s_payload_tready;
    assign w_alloc      = (r_state == ST_CPL) && i_cpl_ready;
    assign w_release    = i_rel_valid && (r_used != '0);

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream gating. The payload is only ever forwarded in DATA
    // and only ever sunk unconditionally in DROP; otherwise the decap is held.
    always_comb begin
        w_state_nxt      = r_state;
        s_payload_tready = 1'b0;
        m_dma_tvalid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = w_bad_hdr ? ST_DROP : ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_cmd_ready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                s_payload_tready = m_dma_tready;
                m_dma_tvalid     = s_payload_tvalid;
                if (s_payload_tvalid && m_dma_tready && s_payload_tlast) begin
                    w_state_nxt = ST_CPL;
                end
            end
            ST_CPL: begin
                if (i_cpl_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_payload_tready = 1'b1;
                if (s_payload_tvalid && s_payload_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-entry header holding register. A header arriving in the same cycle
    // the pending one is consumed is accepted; only a true collision is lost.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pending      <= 1'b0;
            r_hdr_src_ip   <= '0;
            r_hdr_src_port <= '0;
            r_hdr_len      <= '0;
            r_hdr_overflow <= 1'b0;
        end else begin
            if (w_leave_idle) begin
                r_pending <= 1'b0;
            end
            if (i_hdr_valid) begin
                if (!r_pending || w_leave_idle) begin
                    r_pending      <= 1'b1;
                    r_hdr_src_ip   <= i_hdr_src_ip;
                    r_hdr_src_port <= i_hdr_src_port;
                    r_hdr_len      <= i_hdr_payload_len;
                end else begin
                    r_hdr_overflow <= 1'b1;
                end
            end
        end
    end

    // The working copy of the header is taken when IDLE is left so a new
    // header can be parked while this packet is still in flight.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cur_src_ip   <= '0;
            r_cur_src_port <= '0;
            r_cur_len      <= '0;
            r_cmd_addr     <= '0;
            r_cmd_len      <= '0;
            r_drop_count   <= '0;
        end else if (w_leave_idle) begin
            r_cur_src_ip   <= r_hdr_src_ip;
            r_cur_src_port <= r_hdr_src_port;
            r_cur_len      <= r_hdr_len;
            if (w_bad_hdr) begin
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end else begin
                r_cmd_addr <= BUF_BASE_ADDR + (32'(r_wr_idx) * 32'(BUF_SIZE));
                r_cmd_len  <= r_hdr_len;
            end
        end
    end

    // Ring write pointer and used-buffer count. An allocation and a release in
    // the same cycle cancel out.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_wr_idx <= '0;
            r_used   <= '0;
        end else begin
            if (w_alloc) begin
                r_wr_idx <= (r_wr_idx == IDXW'(NUM_BUFS - 1)) ? '0 : r_wr_idx + IDXW'(1);
            end
            case ({w_alloc, w_release})
                2'b10:   r_used <= r_used + (IDXW+1)'(1);
                2'b01:   r_used <= r_used - (IDXW+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

`ifdef RDMA_RX_SEQ_LEN_CHECK_EN
    logic [15:0] r_byte_cnt;

    // Error and byte accounting restart for every accepted packet.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
        end else if (w_leave_idle && !w_bad_hdr) begin
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
        end else if ((r_state == ST_DATA) && w_beat_acc) begin
            r_err      <= r_err | s_payload_tuser;
            r_byte_cnt <= r_byte_cnt + 16'(s_payload_tkeep[0]) + 16'(s_payload_tkeep[1])
                                     + 16'(s_payload_tkeep[2]) + 16'(s_payload_tkeep[3]);
        end
    end

    assign o_cpl_len   = r_byte_cnt;
    assign o_cpl_error = r_err | (r_byte_cnt != r_cur_len);
`else
    // Error accumulation restarts for every accepted packet.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_err <= 1'b0;
        end else if (w_leave_idle && !w_bad_hdr) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_DATA) && w_beat_acc) begin
            r_err <= r_err | s_payload_tuser;
        end
    end

    assign o_cpl_len   = r_cur_len;
    assign o_cpl_error = r_err;
`endif

    assign m_dma_tdata    = s_payload_tdata;
    assign m_dma_tkeep    = s_payload_tkeep;
    assign m_dma_tlast    = s_payload_tlast;

    assign o_cmd_valid    = (r_state == ST_CMD);
    assign o_cmd_addr     = r_cmd_addr;
    assign o_cmd_len      = r_cmd_len;
    assign o_cpl_valid    = (r_state == ST_CPL);
    assign o_cpl_buf_idx  = r_wr_idx;
    assign o_cpl_src_ip   = r_cur_src_ip;
    assign o_cpl_src_port = r_cur_src_port;
    assign o_free_count   = (IDXW+1)'(NUM_BUFS) - r_used;
    assign o_drop_count   = r_drop_count;
    assign o_hdr_overflow = r_hdr_overflow;
    assign o_state        = r_state;

endmodule

// File: tb/tb_rdma_rx_buf_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rdma_rx_buf_sequencer
//
// Drives whole packets (header pulse, payload beats with random gaps and random
// DMA back-pressure, random command/completion delays) and checks the sequencer
// against a packet-level model: a used-buffer count, a ring write index and a
// drop count, updated per packet from the acceptance rules.
// -----------------------------------------------------------------------------
module tb_rdma_rx_buf_sequencer;

    localparam int          NUM_BUFS = 8;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          BUF_SIZE = 2048;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] i_hdr_src_ip = '0;
    logic [15:0] i_hdr_src_port = '0;
    logic [15:0] i_hdr_payload_len = '0;
    logic        i_hdr_valid = 1'b0;
    logic [31:0] s_payload_tdata = '0;
    logic [3:0]  s_payload_tkeep = '0;
    logic        s_payload_tvalid = 1'b0;
    logic        s_payload_tlast = 1'b0;
    logic        s_payload_tuser = 1'b0;
    logic        s_payload_tready;
    logic [31:0] m_dma_tdata;
    logic [3:0]  m_dma_tkeep;
    logic        m_dma_tvalid;
    logic        m_dma_tlast;
    logic        m_dma_tready = 1'b0;
    logic [31:0] o_cmd_addr;
    logic [15:0] o_cmd_len;
    logic        o_cmd_valid;
    logic        i_cmd_ready = 1'b0;
    logic [2:0]  o_cpl_buf_idx;
    logic [15:0] o_cpl_len;
    logic [31:0] o_cpl_src_ip;
    logic [15:0] o_cpl_src_port;
    logic        o_cpl_error;
    logic        o_cpl_valid;
    logic        i_cpl_ready = 1'b0;
    logic        i_rel_valid = 1'b0;
    logic [3:0]  o_free_count;
    logic [15:0] o_drop_count;
    logic        o_hdr_overflow;
    logic [2:0]  o_state;

    int          assertCount = 0;
    int          failCount   = 0;
    int          mUsed  = 0;
    int          mWrIdx = 0;
    int          mDrops = 0;
    bit          abortRun = 1'b0;
    logic [36:0] dmaQ[$];

    always #5 iClk = ~iClk;

    rdma_rx_buf_sequencer #(
        .NUM_BUFS      (NUM_BUFS),
        .BUF_BASE_ADDR (BASE),
        .BUF_SIZE      (BUF_SIZE)
    ) dut (
        .iClk              (iClk),
        .iRst              (iRst),
        .i_hdr_src_ip      (i_hdr_src_ip),
        .i_hdr_src_port    (i_hdr_src_port),
        .i_hdr_payload_len (i_hdr_payload_len),
        .i_hdr_valid       (i_hdr_valid),
        .s_payload_tdata   (s_payload_tdata),
        .s_payload_tkeep   (s_payload_tkeep),
        .s_payload_tvalid  (s_payload_tvalid),
        .s_payload_tlast   (s_payload_tlast),
        .s_payload_tuser   (s_payload_tuser),
        .s_payload_tready  (s_payload_tready),
        .m_dma_tdata       (m_dma_tdata),
        .m_dma_tkeep       (m_dma_tkeep),
        .m_dma_tvalid      (m_dma_tvalid),
        .m_dma_tlast       (m_dma_tlast),
        .m_dma_tready      (m_dma_tready),
        .o_cmd_addr        (o_cmd_addr),
        .o_cmd_len         (o_cmd_len),
        .o_cmd_valid       (o_cmd_valid),
        .i_cmd_ready       (i_cmd_ready),
        .o_cpl_buf_idx     (o_cpl_buf_idx),
        .o_cpl_len         (o_cpl_len),
        .o_cpl_src_ip      (o_cpl_src_ip),
        .o_cpl_src_port    (o_cpl_src_port),
        .o_cpl_error       (o_cpl_error),
        .o_cpl_valid       (o_cpl_valid),
        .i_cpl_ready       (i_cpl_ready),
        .i_rel_valid       (i_rel_valid),
        .o_free_count      (o_free_count),
        .o_drop_count      (o_drop_count),
        .o_hdr_overflow    (o_hdr_overflow),
        .o_state           (o_state)
    );

    // Record every beat the DMA side accepts, in order.
    always @(negedge iClk) begin
        if (!iRst && m_dma_tvalid && m_dma_tready) begin
            dmaQ.push_back({m_dma_tlast, m_dma_tkeep, m_dma_tdata});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkResetValues(input string where);
        checkOutput({where, "_cmd_valid"},   o_cmd_valid, 0);
        checkOutput({where, "_cpl_valid"},   o_cpl_valid, 0);
        checkOutput({where, "_dma_tvalid"},  m_dma_tvalid, 0);
        checkOutput({where, "_tready"},      s_payload_tready, 0);
        checkOutput({where, "_cmd_addr"},    o_cmd_addr, 0);
        checkOutput({where, "_cmd_len"},     o_cmd_len, 0);
        checkOutput({where, "_cpl_idx"},     o_cpl_buf_idx, 0);
        checkOutput({where, "_cpl_len"},     o_cpl_len, 0);
        checkOutput({where, "_cpl_ip"},      o_cpl_src_ip, 0);
        checkOutput({where, "_cpl_port"},    o_cpl_src_port, 0);
        checkOutput({where, "_cpl_error"},   o_cpl_error, 0);
        checkOutput({where, "_free_count"},  o_free_count, NUM_BUFS);
        checkOutput({where, "_drop_count"},  o_drop_count, 0);
        checkOutput({where, "_overflow"},    o_hdr_overflow, 0);
        checkOutput({where, "_state"},       o_state, 0);
    endtask

    task automatic releaseBuf();
        i_rel_valid = 1'b1;
        tick();
        i_rel_valid = 1'b0;
        if (mUsed > 0) mUsed--;
        checkOutput("rel_free_count", o_free_count, NUM_BUFS - mUsed);
    endtask

    // One complete packet: header, command, payload, completion (or drain).
    task automatic applyStimulus(input int len, input int nBeats, input int userBeat, input bit allowRel);
        bit          accept;
        bit          anyUser;
        bit          relNow;
        bit          got;
        int          budget;
        int          bytes;
        int          expLen;
        bit          expErr;
        logic [31:0] ip;
        logic [15:0] port;
        logic [31:0] expAddr;
        logic [36:0] expQ[$];

        if (abortRun) return;
        accept  = (len != 0) && (len <= BUF_SIZE) && (mUsed < NUM_BUFS);
        ip      = $urandom;
        port    = 16'($urandom);
        expAddr = BASE + 32'(mWrIdx * BUF_SIZE);

        i_hdr_src_ip      = ip;
        i_hdr_src_port    = port;
        i_hdr_payload_len = 16'(len);
        i_hdr_valid       = 1'b1;
        tick();
        i_hdr_valid  = 1'b0;
        m_dma_tready = 1'b1;
        tick();
        checkOutput("state_after_hdr", o_state, accept ? 1 : 4);
        checkOutput("cmd_valid", o_cmd_valid, accept);
        if (!accept) begin
            mDrops++;
            checkOutput("drop_count", o_drop_count, mDrops);
            checkOutput("drop_tready", s_payload_tready, 1);
        end else begin
            checkOutput("cmd_addr", o_cmd_addr, expAddr);
            checkOutput("cmd_len", o_cmd_len, len);
            checkOutput("cmd_tready_low", s_payload_tready, 0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                checkOutput("cmd_hold_valid", o_cmd_valid, 1);
                checkOutput("cmd_hold_addr", o_cmd_addr, expAddr);
            end
            i_cmd_ready = 1'b1;
            tick();
            i_cmd_ready = 1'b0;
        end

        bytes   = 0;
        anyUser = 1'b0;
        for (int b = 0; b < nBeats && !abortRun; b++) begin
            logic [3:0]  keep;
            logic [31:0] data;
            bit          last;
            bit          user;
            last = (b == nBeats - 1);
            keep = 4'hF;
            if (last && (nBeats == (len + 3) / 4) && ((len % 4) != 0)) keep = 4'((1 << (len % 4)) - 1);
            data = $urandom;
            user = (b == userBeat);
            s_payload_tdata = data;
            s_payload_tkeep = keep;
            s_payload_tlast = last;
            s_payload_tuser = user;
            got    = 1'b0;
            budget = 0;
            while (!got) begin
                s_payload_tvalid = ($urandom_range(0, 3) != 0);
                m_dma_tready     = 1'($urandom_range(0, 1));
                @(negedge iClk);
                if (accept) begin
                    checkOutput("tready_mirror", s_payload_tready, m_dma_tready);
                    checkOutput("dma_tvalid_pass", m_dma_tvalid, s_payload_tvalid);
                end else begin
                    checkOutput("drain_tready", s_payload_tready, 1);
                    checkOutput("drain_no_dma", m_dma_tvalid, 0);
                end
                got = s_payload_tvalid && s_payload_tready;
                tick();
                budget++;
                if (!got && budget > 200) begin
                    checkOutput("beat_accepted", got, 1);
                    abortRun = 1'b1;
                    break;
                end
            end
            if (got) begin
                bytes += $countones(keep);
                anyUser |= user;
                if (accept) expQ.push_back({last, keep, data});
            end
        end
        s_payload_tvalid = 1'b0;
        s_payload_tlast  = 1'b0;
        s_payload_tuser  = 1'b0;
        if (abortRun) return;

        if (accept) begin
`ifdef RDMA_RX_SEQ_LEN_CHECK_EN
            expLen = bytes;
            expErr = anyUser || (bytes != len);
`else
            expLen = len;
            expErr = anyUser;
`endif
            m_dma_tready = 1'b1;
            checkOutput("cpl_valid", o_cpl_valid, 1);
            checkOutput("cpl_state", o_state, 3);
            checkOutput("cpl_idx", o_cpl_buf_idx, mWrIdx);
            checkOutput("cpl_len", o_cpl_len, expLen);
            checkOutput("cpl_ip", o_cpl_src_ip, ip);
            checkOutput("cpl_port", o_cpl_src_port, port);
            checkOutput("cpl_error", o_cpl_error, expErr);
            checkOutput("cpl_tready_low", s_payload_tready, 0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                checkOutput("cpl_hold_valid", o_cpl_valid, 1);
                checkOutput("cpl_hold_idx", o_cpl_buf_idx, mWrIdx);
            end
            relNow      = allowRel && (mUsed > 0) && ($urandom_range(0, 2) == 0);
            i_cpl_ready = 1'b1;
            i_rel_valid = relNow;
            tick();
            i_cpl_ready = 1'b0;
            i_rel_valid = 1'b0;
            if (relNow) mUsed--;
            mUsed++;
            mWrIdx = (mWrIdx + 1) % NUM_BUFS;
            checkOutput("cpl_done_valid", o_cpl_valid, 0);
        end
        checkOutput("state_idle_after", o_state, 0);
        checkOutput("free_count", o_free_count, NUM_BUFS - mUsed);
        checkOutput("dma_beat_count", dmaQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < dmaQ.size(); i++) begin
            checkOutput("dma_beat", dmaQ[i], expQ[i]);
        end
        dmaQ.delete();
    endtask

    function automatic int beatsFor(input int len);
        return (len <= 0) ? 1 : (len + 3) / 4;
    endfunction

    initial begin
        $display("[TB] start");
        tick();
        tick();
        checkResetValues("rst_init");
        iRst = 1'b0;
        tick();

        // Basic packet, then fill the ring and overflow it by one.
        applyStimulus(64, 16, -1, 1'b0);
        for (int p = 0; p < 7; p++) begin
            int len;
            len = $urandom_range(1, 64);
            applyStimulus(len, beatsFor(len), -1, 1'b0);
        end
        checkOutput("ring_full", o_free_count, 0);
        applyStimulus(32, 8, -1, 1'b0);
        checkOutput("drop_when_full", o_drop_count, 1);
        releaseBuf();
        applyStimulus(40, 10, -1, 1'b0);
        for (int r = 0; r < NUM_BUFS + 1; r++) releaseBuf();
        checkOutput("all_free", o_free_count, NUM_BUFS);

        // Length boundaries, error flag and short packet.
        applyStimulus(4096, 4, -1, 1'b0);
        applyStimulus(0, 1, -1, 1'b0);
        applyStimulus(BUF_SIZE, beatsFor(BUF_SIZE), -1, 1'b0);
        applyStimulus(BUF_SIZE + 1, 3, -1, 1'b0);
        applyStimulus(64, 16, 3, 1'b0);
        applyStimulus(64, 15, -1, 1'b0);
        for (int r = 0; r < 3; r++) releaseBuf();

        // Header collision while busy, then reset in the middle of a payload.
        if (!abortRun) begin
            i_hdr_src_ip      = 32'hC0A8_0001;
            i_hdr_src_port    = 16'd4791;
            i_hdr_payload_len = 16'd32;
            i_hdr_valid       = 1'b1;
            tick();
            i_hdr_valid = 1'b0;
            tick();
            checkOutput("ovf_cmd_valid", o_cmd_valid, 1);
            i_hdr_valid = 1'b1;
            tick();
            checkOutput("ovf_first_parked", o_hdr_overflow, 0);
            tick();
            i_hdr_valid = 1'b0;
            checkOutput("ovf_set", o_hdr_overflow, 1);
            tick();
            checkOutput("ovf_sticky", o_hdr_overflow, 1);
            i_cmd_ready = 1'b1;
            tick();
            i_cmd_ready      = 1'b0;
            m_dma_tready     = 1'b1;
            s_payload_tvalid = 1'b1;
            s_payload_tkeep  = 4'hF;
            s_payload_tdata  = 32'hDEAD_BEEF;
            tick();
            tick();
            iRst = 1'b1;
            tick();
            checkResetValues("rst_mid");
            iRst             = 1'b0;
            s_payload_tvalid = 1'b0;
            mUsed  = 0;
            mWrIdx = 0;
            mDrops = 0;
            dmaQ.delete();
            tick();
            tick();
            checkOutput("post_rst_state", o_state, 0);
            checkOutput("post_rst_cmd_valid", o_cmd_valid, 0);
        end

        // Randomized traffic with occasional drops, errors and length slips.
        for (int p = 0; p < 60 && !abortRun; p++) begin
            int len;
            int nb;
            int ub;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                len = 0;
                nb  = $urandom_range(1, 3);
            end else if (sel == 1) begin
                len = $urandom_range(BUF_SIZE + 1, 4096);
                nb  = $urandom_range(1, 6);
            end else begin
                len = $urandom_range(1, 160);
                nb  = beatsFor(len);
                if ($urandom_range(0, 6) == 0) nb = (nb > 1) ? nb - 1 : nb + 1;
            end
            ub = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
            applyStimulus(len, nb, ub, 1'b1);
            repeat ($urandom_range(0, 1)) releaseBuf();
        end
        checkOutput("final_drop_count", o_drop_count, mDrops);
        checkOutput("final_overflow", o_hdr_overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
